// File: rtl/i2c_sensor_cfg_seq_pkg.sv
// Shared types and constants for the I2C sensor register sequencer.
// Holds the FSM encoding, default slave address and error-index sentinel.
package i2c_sensor_cfg_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT,
        S_CHECK,
        S_NEXT,
        S_UPD,
        S_ERROR
    } seq_state_e;

    localparam logic [7:0] SLAVE_ADDR_DEF = 8'hBA;

    // Sliced to IDX_W in the top; marks a failed one-shot update write.
    localparam logic [31:0] ERR_IDX_UPD = '1;

    function automatic int tick_div(input int clk_f, input int i2c_f);
        return clk_f / (2 * i2c_f);
    endfunction

endpackage

// File: rtl/i2c_tick_gen.sv
// Free-running clock-enable generator for the I2C master.
// Emits a one-cycle pulse every CLK_FREQ/(2*I2C_FREQ) clocks.
module i2c_tick_gen
    import i2c_sensor_cfg_seq_pkg::*;
#(
    parameter int CLK_FREQ = 50000000,
    parameter int I2C_FREQ = 20000
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic tick_o
);

    localparam int DIV = tick_div(CLK_FREQ, I2C_FREQ);
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == CW'(DIV - 1));

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (tick_o) cnt_d = '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

endmodule

// File: rtl/i2c_sensor_cfg_seq.sv
// CMOS sensor register sequencer: walks an external config table into
// the I2C master, retries NACKs, and services one-shot register updates.
module i2c_sensor_cfg_seq
    import i2c_sensor_cfg_seq_pkg::*;
#(
    parameter int         CLK_FREQ    = 50000000,
    parameter int         I2C_FREQ    = 20000,
    parameter logic [7:0] SLAVE_ADDR  = SLAVE_ADDR_DEF,
    parameter int         REG_AW      = 8,
    parameter int         REG_DW      = 16,
    parameter int         LUT_SIZE    = 25,
    parameter int         IDX_W       = 6,
    parameter int         MAX_RETRY   = 3,
    parameter int         STOP_ON_ERR = 0,
    parameter int         AUTO_START  = 1
) (
    input  logic                     iCLK,
    input  logic                     iRST_N,
    input  logic                     iSTART,
    input  logic                     iUPD_REQ,
    input  logic [REG_AW-1:0]        iUPD_ADDR,
    input  logic [REG_DW-1:0]        iUPD_DATA,
    output logic [IDX_W-1:0]         oLUT_IDX,
    input  logic [REG_AW+REG_DW-1:0] iLUT_DATA,
    output logic                     oTICK,
    output logic [8+REG_AW+REG_DW-1:0] oTX_DATA,
    output logic                     oTX_GO,
    input  logic                     iTX_END,
    input  logic                     iTX_NACK,
    output logic                     oBUSY,
    output logic                     oDONE,
    output logic                     oERR,
    output logic [IDX_W-1:0]         oERR_IDX
);

    localparam int TW = 8 + REG_AW + REG_DW;
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(LUT_SIZE - 1);
    localparam logic [IDX_W-1:0] UPD_IDX   = ERR_IDX_UPD[IDX_W-1:0];
    localparam logic [RW-1:0]    RETRY_MAX = RW'(MAX_RETRY);

    seq_state_e        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [TW-1:0]     txd_q, txd_d;
    logic [RW-1:0]     retry_q, retry_d;
    logic              nack_q, nack_d;
    logic              is_upd_q, is_upd_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [IDX_W-1:0]  err_idx_q, err_idx_d;
    logic              start_pend_q, start_pend_d;
    logic              upd_pend_q, upd_pend_d;
    logic [REG_AW-1:0] upd_addr_q, upd_addr_d;
    logic [REG_DW-1:0] upd_data_q, upd_data_d;
    logic              auto_q, auto_d;

    logic start_req;
    logic restart;
    logic advance;

    i2c_tick_gen #(
        .CLK_FREQ (CLK_FREQ),
        .I2C_FREQ (I2C_FREQ)
    ) u_tick (
        .clk_i  (iCLK),
        .rst_ni (iRST_N),
        .tick_o (oTICK)
    );

    assign start_req = start_pend_q | iSTART;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        txd_d        = txd_q;
        retry_d      = retry_q;
        nack_d       = nack_q;
        is_upd_d     = is_upd_q;
        done_d       = done_q;
        err_d        = err_q;
        err_idx_d    = err_idx_q;
        start_pend_d = start_req;
        upd_pend_d   = upd_pend_q;
        upd_addr_d   = upd_addr_q;
        upd_data_d   = upd_data_q;
        auto_d       = 1'b0;
        restart      = 1'b0;
        advance      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start_req || auto_q) restart = 1'b1;
                else if (upd_pend_q)     state_d = S_UPD;
            end
            S_FETCH: begin
                txd_d    = {SLAVE_ADDR, iLUT_DATA};
                is_upd_d = 1'b0;
                state_d  = S_ISSUE;
            end
            S_UPD: begin
                txd_d      = {SLAVE_ADDR, upd_addr_q, upd_data_q};
                upd_pend_d = 1'b0;
                is_upd_d   = 1'b1;
                retry_d    = '0;
                state_d    = S_ISSUE;
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (iTX_END) begin
                    nack_d  = iTX_NACK;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                unique case (1'b1)
                    !nack_q: begin
                        retry_d = '0;
                        advance = 1'b1;
                    end
                    nack_q && (retry_q != RETRY_MAX): begin
                        retry_d = retry_q + RW'(1);
                        state_d = S_ISSUE;
                    end
                    nack_q && (retry_q == RETRY_MAX): begin
                        retry_d = '0;
                        err_d   = 1'b1;
                        if (!err_q) err_idx_d = is_upd_q ? UPD_IDX : idx_q;
                        if (STOP_ON_ERR != 0) state_d = S_ERROR;
                        else                  advance = 1'b1;
                    end
                    default: state_d = S_CHECK;
                endcase
            end
            S_NEXT: begin
                if (is_upd_q) begin
                    state_d = S_IDLE;
                end else if (idx_q == LAST_IDX) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = S_FETCH;
                end
            end
            S_ERROR: begin
                if (start_req) restart = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        // A start latched mid-run takes effect only once a write has settled.
        if (advance) begin
            if (start_req) restart = 1'b1;
            else           state_d = S_NEXT;
        end

        if (restart) begin
            state_d      = S_FETCH;
            idx_d        = '0;
            retry_d      = '0;
            is_upd_d     = 1'b0;
            done_d       = 1'b0;
            err_d        = 1'b0;
            start_pend_d = 1'b0;
        end

        if (iUPD_REQ) begin
            upd_pend_d = 1'b1;
            upd_addr_d = iUPD_ADDR;
            upd_data_d = iUPD_DATA;
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            txd_q        <= '0;
            retry_q      <= '0;
            nack_q       <= 1'b0;
            is_upd_q     <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            err_idx_q    <= '0;
            start_pend_q <= 1'b0;
            upd_pend_q   <= 1'b0;
            upd_addr_q   <= '0;
            upd_data_q   <= '0;
            auto_q       <= (AUTO_START != 0);
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            txd_q        <= txd_d;
            retry_q      <= retry_d;
            nack_q       <= nack_d;
            is_upd_q     <= is_upd_d;
            done_q       <= done_d;
            err_q        <= err_d;
            err_idx_q    <= err_idx_d;
            start_pend_q <= start_pend_d;
            upd_pend_q   <= upd_pend_d;
            upd_addr_q   <= upd_addr_d;
            upd_data_q   <= upd_data_d;
            auto_q       <= auto_d;
        end
    end

    assign oLUT_IDX = idx_q;
    assign oTX_DATA = txd_q;
    assign oTX_GO   = (state_q == S_ISSUE) || (state_q == S_WAIT);
    assign oBUSY    = (state_q != S_IDLE) && (state_q != S_ERROR);
    assign oDONE    = done_q;
    assign oERR     = err_q;
    assign oERR_IDX = err_idx_q;

endmodule
